// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3 engine).
//
// Takes a BIN_W-bit binary value on an accepted start and shifts it through
// a (16+BIN_W)-bit register for BIN_W cycles. It presents four registered
// BCD digits (thousands..ones), and those digits only change when a
// conversion completes.
//
// Optional feature: define BIN2BCD_SATURATE_EN to show 9999 instead of the
// value mod 10000 when the latched input was above 9999.
//
// Handshake: start is sampled on a rising clock edge only while busy=0 (IDLE
// or DONE state); that edge is the accept edge and latches bin_in. busy stays
// high for BIN_W cycles after it. done is high for exactly the one cycle in
// which the new digits are first visible. The DONE cycle is not busy, so a
// start there chains straight into the next conversion.
//
// dbg_state_o mirrors the FSM state encoding: IDLE=0, SHIFT=1, DONE=2.
module bin2bcd_seq #(
    parameter int BIN_W = 14
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [3:0]       dig0,
    output logic [3:0]       dig1,
    output logic [3:0]       dig2,
    output logic [3:0]       dig3,
    output logic [1:0]       dbg_state_o
);

    localparam int SR_W  = 16 + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [15:0]       dig_q, dig_d;

    logic [SR_W-1:0]   sr_adj;
    logic [SR_W-1:0]   sr_shift;
    logic              in_ovf;
    logic [15:0]       result;

    // Adjust each BCD nibble (>=5 gets +3), then shift the whole register left.
    // The bit leaving the thousands nibble is dropped, giving value mod 10000.
    always_comb begin
        sr_adj = sr_q;
        for (int i = 0; i < 4; i++) begin
            if (sr_q[BIN_W + 4*i +: 4] >= 4'd5) begin
                sr_adj[BIN_W + 4*i +: 4] = sr_q[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
        sr_shift = {sr_adj[SR_W-2:0], 1'b0};
    end

    assign in_ovf = ({{(32-BIN_W){1'b0}}, bin_in} > 32'd9999);

    // Value loaded into the digits on the DONE-entry edge.
`ifdef BIN2BCD_SATURATE_EN
    assign result = ovf_q ? 16'h9999 : sr_shift[SR_W-1 -: 16];
`else
    assign result = sr_shift[SR_W-1 -: 16];
`endif

    // Next-state and datapath updates for the IDLE/SHIFT/DONE controller.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        dig_d   = dig_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sr_d    = {16'b0, bin_in};
                    cnt_d   = CNT_W'(BIN_W);
                    ovf_d   = in_ovf;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                sr_d  = sr_shift;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    dig_d   = result;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            dig_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            dig_q   <= dig_d;
        end
    end

    assign busy        = (state_q == SHIFT);
    assign done        = (state_q == DONE);
    assign overflow    = ovf_q;
    assign dig0        = dig_q[3:0];
    assign dig1        = dig_q[7:4];
    assign dig2        = dig_q[11:8];
    assign dig3        = dig_q[15:12];
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: directed cases plus randomized conversions,
// checked by a scoreboard against an arithmetic reference model.
module tb_bin2bcd_seq;

    localparam int BIN_W = 14;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [BIN_W-1:0] bin_in;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [3:0]       dig0, dig1, dig2, dig3;
    logic [1:0]       dbg_state_o;

    int total = 0;
    int bad   = 0;

    // expected entry: {overflow, thousands, hundreds, tens, ones}
    logic [16:0] exp_q[$];

    bin2bcd_seq #(.BIN_W(BIN_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .bin_in      (bin_in),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .dig0        (dig0),
        .dig1        (dig1),
        .dig2        (dig2),
        .dig3        (dig3),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int digits_now();
        return int'({dig3, dig2, dig1, dig0});
    endfunction

    // Reference: decimal digits of the value mod 10000 (or 9999 when saturating).
    function automatic logic [16:0] model(input int v);
        int  r;
        logic ovf;
        ovf = (v > 9999);
        r   = v % 10000;
`ifdef BIN2BCD_SATURATE_EN
        if (ovf) r = 9999;
`endif
        return {ovf, 4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
    endfunction

    // ---------------- driver ----------------
    // Drive one cycle of inputs at the falling edge; a start seen while idle
    // will be accepted on the next rising edge, so its expectation is queued.
    task automatic drive_cycle(input logic s, input int v);
        @(negedge clock);
        start  = s;
        bin_in = BIN_W'(v);
        if (s && !busy && !reset) exp_q.push_back(model(int'(bin_in)));
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            drive_cycle(1'b0, int'($urandom_range(0, 16383)));
            n++;
        end while ((busy || done) && n < budget);
        if (busy || done) begin
            total++;
            bad++;
            $display("FAIL wait_idle timeout actual=busy required=idle");
        end
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic apply_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            reset  = 1'b1;
            start  = 1'b1;
            bin_in = BIN_W'($urandom_range(0, 16383));
        end
        @(negedge clock);
        exp_q.delete();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_digits", digits_now(), 0);
        chk("rst_state", int'(dbg_state_o), 0);
        reset = 1'b0;
        start = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        rst_s = 1'b1;
    logic        prev_done = 1'b0;
    int          prev_dig = 0;
    int          busy_run = 0;
    int          cyc = 0;
    int          last_done_cyc = 0;
    int          done_gap = 0;

    always @(posedge clock) rst_s <= reset;

    always @(negedge clock) begin
        logic [16:0] e;
        cyc++;
        if (done) begin
            if (prev_done) begin
                total++;
                bad++;
                $display("FAIL done_width actual=2+ cycles required=1");
            end
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done actual=done required=no_done digits=%h", digits_now());
            end else begin
                e = exp_q.pop_front();
                chk("digits", digits_now(), int'(e[15:0]));
                chk("overflow", int'(overflow), int'(e[16]));
                chk("busy_len", busy_run, BIN_W);
            end
            done_gap      = cyc - last_done_cyc;
            last_done_cyc = cyc;
        end
        if (digits_now() != prev_dig && !done && !rst_s) begin
            total++;
            bad++;
            $display("FAIL digit_stability actual=%h required=%h", digits_now(), prev_dig);
        end
        if (rst_s || !busy) busy_run = 0;
        else                busy_run++;
        prev_done = done;
        prev_dig  = digits_now();
    end

    // ---------------- stimulus ----------------
    initial begin
        int v;
        int k;
        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;

        // Reset held 3 cycles with start high: nothing may start.
        apply_reset(3);
        drive_cycle(1'b0, 0);
        chk("no_start_after_reset", int'(busy), 0);

        // Single conversion.
        drive_cycle(1'b1, 1234);
        wait_idle(40);

        // Back-to-back with start held: 0 then 9999.
        drive_cycle(1'b1, 0);
        for (int i = 0; i < 15; i++) drive_cycle(1'b1, 9999);
        drive_cycle(1'b0, 0);
        wait_idle(40);
        chk("b2b_done_gap", done_gap, BIN_W + 1);

        // Out of range.
        drive_cycle(1'b1, 12345);
        wait_idle(40);
        chk("ovf_held", int'(overflow), 1);

        // Ignored starts during a conversion; old digits held meanwhile.
        drive_cycle(1'b1, 42);
        wait_idle(40);
        drive_cycle(1'b1, 56);
        for (int i = 1; i <= 13; i++) begin
            drive_cycle((i == 3) || (i == 10), 777);
            chk("hold_digits", digits_now(), 16'h0042);
        end
        wait_idle(40);
        chk("after_56", digits_now(), 16'h0056);

        // Reset in the middle of a conversion of 4321.
        drive_cycle(1'b1, 4321);
        for (int i = 1; i < 7; i++) drive_cycle(1'b0, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        exp_q.delete();
        reset = 1'b0;
        chk("midrst_state", int'(dbg_state_o), 0);
        chk("midrst_digits", digits_now(), 0);
        chk("midrst_busy", int'(busy), 0);
        for (int i = 0; i < 20; i++) drive_cycle(1'b0, 0);

        // Randomized conversions with stray starts while busy.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       v = int'($urandom_range(9990, 10010));
                1:       v = int'($urandom_range(0, 99));
                default: v = int'($urandom_range(0, (1 << BIN_W) - 1));
            endcase
            drive_cycle(1'b1, v);
            drive_cycle(1'b0, 0);
            k = 0;
            while ((busy || done) && k < 200) begin
                drive_cycle($urandom_range(0, 3) == 0, int'($urandom_range(0, 16383)));
                k++;
            end
            wait_idle(60);
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) drive_cycle(1'b0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter feeding the four-digit seven-segment driver. It accepts a binary count, converts it with an iterative shift-and-add-3 (double-dabble) engine, and presents four registered BCD digits that connect directly to the driver's `dig0`..`dig3` inputs. Digits hold their previous value during a conversion, so the display never shows partial results.

## Interface
- `BIN_W`, 14, width of the binary input; legal range 4..14.
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  conversion request; sampled only when `busy`=0.
- `bin_in`  in  BIN_W  binary value; latched on the accepted `start`.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse; the digits have just been updated.
- `overflow`  out  1  latched value of the last accepted input was greater than 9999.
- `dig0`  out  4  BCD ones.
- `dig1`  out  4  BCD tens.
- `dig2`  out  4  BCD hundreds.
- `dig3`  out  4  BCD thousands.

## Operation
- **States:** IDLE, SHIFT, DONE.
- **Reset values:** state IDLE; `busy`=0, `done`=0, `overflow`=0, `dig0`..`dig3`=0; shift register and counter cleared.
- **IDLE / DONE** (`busy`=0). `start`=1 does the following:
  - load `{16'b0, bin_in}` into a (16+BIN_W)-bit shift register;
  - set counter to BIN_W;
  - capture `overflow` = (`bin_in` > 9999);
  - go to SHIFT.
- **IDLE / DONE, no start:** IDLE stays in IDLE; DONE goes to IDLE.
- **SHIFT, each cycle:**
  - each of the four BCD nibbles ≥ 5 gets +3 (adjust);
  - then the whole register shifts left by 1;
  - counter decrements;
  - the bit shifted out of the thousands nibble is discarded.
- **SHIFT exit:** after the BIN_W-th shift, go to DONE. The DONE-entry edge registers the BCD nibbles into `dig0`..`dig3`.
- **`done`:** equals 1 exactly in the DONE state.
- **Ignored start:** `start` while `busy`=1 is ignored; no queueing, and `bin_in` changes have no effect.
- **Back-to-back:** `start` in the DONE cycle is accepted and begins the next conversion immediately.
- **Out-of-range inputs:** without the configuration macro, results equal `bin_in` mod 10000. Every digit is always valid BCD (0..9).
- **Reset mid-conversion:** `reset` in any state aborts the conversion and restores all reset values; the displayed digits go to 0.

## Timing
- **Handshake:** `start` accepted at rising edge k.
  - `busy`=1 from k+1 through the cycle before edge k+BIN_W+1.
  - Edge k+BIN_W+1: digits update, `done`=1, `busy`=0 for one cycle.
- **Latency:** BIN_W+1 cycles from accepted `start` to valid digits; 15 for the default.
- **Throughput:** one conversion per BIN_W+1 cycles when `start` is held high.
- **Digit stability:**
  - `dig0`..`dig3` change only at DONE-entry edges and on reset;
  - all four digits change on the same edge;
  - they are stable at all other times.
- **Overflow timing:** `overflow` updates on the accept edge and holds until the next accept or reset.

## Configuration
- **Macro:** `BIN2BCD_SATURATE_EN`.
- **Defined:** when the latched `overflow`=1, the DONE-entry edge loads 9,9,9,9 into `dig3`..`dig0` instead of the engine result. Latency is unchanged.
- **Undefined:** digits always take the engine result (value mod 10000). `overflow` is still reported.

## Test plan
- Reset held 3 cycles with `start`=1 → `busy`=0, `done`=0, `overflow`=0, all digits 0; no conversion starts.
- `bin_in`=1234, `start` pulse → `busy` high 14 cycles; at cycle 15: `done`=1 for 1 cycle, `dig3`..`dig0`=1,2,3,4, `overflow`=0.
- `bin_in`=0, then 9999, converted back-to-back with `start` held high → digits 0,0,0,0 then 9,9,9,9; `done` pulses 15 cycles apart.
- `bin_in`=12345 → `overflow`=1.
  - Without macro: digits 2,3,4,5.
  - With `BIN2BCD_SATURATE_EN`: digits 9,9,9,9.
- Convert 42, then pulse `start` with `bin_in`=777 at cycles 3 and 10 of a second conversion of 56 → both pulses ignored; result 0,0,5,6; digits read 0,0,4,2 until the DONE edge.
- `reset` asserted at cycle 7 of a conversion of 4321 → next cycle: state IDLE, digits 0, `done` never pulses for 4321.
